// File: rtl/rom_burst_reader_pkg.sv
// Shared ROM initiator definitions: geometry, FSM state encoding and burst-length decode.
package rom_burst_reader_pkg;

  localparam int unsigned ROM_ADDR_W = 4;
  localparam int unsigned ROM_DATA_W = 8;
  localparam int unsigned ROM_DEPTH  = 16;
  localparam int unsigned LEN_W      = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StHold  = 2'd2,
    StFin   = 2'd3
  } state_e;

  // A zero length means a full sweep of the ROM.
  function automatic logic [LEN_W-1:0] beats_of(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(ROM_DEPTH) : len;
  endfunction

endpackage

// File: rtl/rom_burst_reader_addr_gen.sv
// Loadable wrap-around address counter with a beat down-counter and last-beat flag.
module rom_burst_reader_addr_gen
  import rom_burst_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last_beat
);

  logic [LEN_W-1:0] remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= beats_of(len);
    end else if (advance && remaining != '0) begin
      addr      <= addr + ADDR_W'(1);
      remaining <= remaining - LEN_W'(1);
    end
  end

  assign last_beat = (remaining == LEN_W'(1));

endmodule

// File: rtl/rom_burst_reader.sv
// Burst read initiator for the 16x8 ROM with a valid/ready byte stream.
// Optional BURST_CHECKSUM_EN adds a per-burst XOR checksum output chk.
module rom_burst_reader
  import rom_burst_reader_pkg::*;
#(
  parameter int unsigned ADDR_W   = ROM_ADDR_W,
  parameter int unsigned DATA_W   = ROM_DATA_W,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              rom_cs,
  output logic              rom_read_en,
  output logic [ADDR_W-1:0] rom_addrb,
  input  logic [DATA_W-1:0] rom_datab,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready
`ifdef BURST_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] chk
`endif
);

  localparam int unsigned WaitW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  state_e           state;
  logic [WaitW-1:0] wait_cnt;
  logic             load;
  logic             advance;
  logic             last_beat;

  assign load    = (state == StIdle) && start;
  assign advance = (state == StHold) && dout_ready;

  // The address register doubles as the ROM address bus.
  rom_burst_reader_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .base      (base_addr),
    .len       (burst_len),
    .advance   (advance),
    .addr      (rom_addrb),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rom_cs      <= 1'b0;
      rom_read_en <= 1'b0;
      dout        <= '0;
      dout_valid  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            state       <= StIssue;
            busy        <= 1'b1;
            rom_cs      <= 1'b1;
            rom_read_en <= 1'b1;
            wait_cnt    <= '0;
          end
        end
        StIssue: begin
          // rom_datab is only trusted on the final cycle of the access window.
          if (wait_cnt == WaitW'(WAIT_CYC - 1)) begin
            state       <= StHold;
            dout        <= rom_datab;
            dout_valid  <= 1'b1;
            rom_cs      <= 1'b0;
            rom_read_en <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + WaitW'(1);
          end
        end
        StHold: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            if (last_beat) begin
              state <= StFin;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state       <= StIssue;
              rom_cs      <= 1'b1;
              rom_read_en <= 1'b1;
              wait_cnt    <= '0;
            end
          end
        end
        StFin: begin
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef BURST_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      chk <= '0;
    end else if (load) begin
      chk <= '0;
    end else if (advance) begin
      chk <= chk ^ dout;
    end
  end
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader against a ROM holding mem[i] = 8'hA0 + i.
module tb_rom_burst_reader;

  localparam int unsigned W = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] burst_len;
  logic       busy;
  logic       done;
  logic       rom_cs;
  logic       rom_read_en;
  logic [3:0] rom_addrb;
  wire  [7:0] rom_datab;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
`ifdef BURST_CHECKSUM_EN
  logic [7:0] chk;
`endif

  logic [7:0] rom_mem [16];

  always #5 clk = ~clk;

  assign rom_datab = (rom_cs && rom_read_en) ? rom_mem[rom_addrb] : 8'hzz;

  rom_burst_reader #(
    .ADDR_W   (4),
    .DATA_W   (8),
    .WAIT_CYC (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .burst_len   (burst_len),
    .busy        (busy),
    .done        (done),
    .rom_cs      (rom_cs),
    .rom_read_en (rom_read_en),
    .rom_addrb   (rom_addrb),
    .rom_datab   (rom_datab),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready)
`ifdef BURST_CHECKSUM_EN
    ,
    .chk         (chk)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Observations gathered by collect_burst.
  logic [7:0] obs_data [$];
  logic [3:0] obs_addr [$];
  int         obs_cyc  [$];
  int         done_cnt, done_cyc, busy_bad, stall_bad;
  bit         timed_out;
  logic [7:0] done_chk;

  function automatic logic [7:0] exp_byte(input int a);
    logic [3:0] w;
    w = 4'(a % 16);
    return 8'hA0 + {4'h0, w};
  endfunction

  function automatic int exp_beats(input logic [4:0] l);
    return (l == 5'd0) ? 16 : int'(l);
  endfunction

  // mode 0: ready always high, 1: random ready, 2: stall beat stall_beat for stall_n cycles.
  task automatic collect_burst(input logic [3:0] b, input logic [4:0] l, input int mode,
                               input int stall_beat, input int stall_n, input int inject_at,
                               input bit start_in_fin);
    int cyc, post, stall_left;
    bit got_done, prev_stall;
    logic [7:0] prev_dout;
    obs_data.delete(); obs_addr.delete(); obs_cyc.delete();
    done_cnt = 0; done_cyc = -1; busy_bad = 0; stall_bad = 0; timed_out = 0; done_chk = '0;
    cyc = 0; post = 0; stall_left = stall_n; got_done = 0; prev_stall = 0; prev_dout = '0;
    @(negedge clk);
    start = 1'b1; base_addr = b; burst_len = l; dout_ready = 1'b0;
    while (post < 3 && cyc < 600) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == inject_at) begin
        start = 1'b1; base_addr = 4'($urandom); burst_len = 5'($urandom);
      end
      if (prev_stall && (dout_valid !== 1'b1 || dout !== prev_dout)) stall_bad++;
      if (dout_valid === 1'b1 && (rom_cs !== 1'b0 || rom_read_en !== 1'b0)) stall_bad++;
      case (mode)
        0: dout_ready = 1'b1;
        1: dout_ready = 1'($urandom_range(0, 1));
        default: begin
          if (dout_valid === 1'b1 && obs_data.size() == stall_beat && stall_left > 0) begin
            dout_ready = 1'b0;
            stall_left--;
          end else begin
            dout_ready = 1'b1;
          end
        end
      endcase
      if (dout_valid === 1'b1 && dout_ready) begin
        obs_data.push_back(dout); obs_addr.push_back(rom_addrb); obs_cyc.push_back(cyc);
      end
      prev_stall = (dout_valid === 1'b1) && !dout_ready;
      prev_dout  = dout;
      if (done === 1'b1) begin
        done_cnt++;
        if (!got_done) begin
          done_cyc = cyc;
`ifdef BURST_CHECKSUM_EN
          done_chk = chk;
`endif
        end
        got_done = 1;
        if (start_in_fin) begin
          start = 1'b1; base_addr = 4'($urandom); burst_len = 5'($urandom);
        end
      end
      if (got_done ? (busy !== 1'b0) : (busy !== 1'b1)) busy_bad++;
      if (got_done) post++;
      cyc++;
    end
    start = 1'b0;
    dout_ready = 1'b0;
    if (!got_done) timed_out = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; burst_len = '0; dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (rom_cs !== 1'b0 || rom_read_en !== 1'b0) begin
      bad++; $display("FAIL reset_rom_ctl got=%b%b want=00", rom_cs, rom_read_en);
    end
    total++; if (rom_addrb !== 4'd0) begin
      bad++; $display("FAIL reset_addrb got=%h want=0", rom_addrb);
    end
    total++; if (dout !== 8'd0 || dout_valid !== 1'b0) begin
      bad++; $display("FAIL reset_dout got=%h/%b want=00/0", dout, dout_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    collect_burst(4'd2, 5'd3, 0, 0, 0, -1, 0);
    total++; if (timed_out || obs_data.size() != 3) begin
      bad++; $display("FAIL basic_count got=%0d want=3 timeout=%0d", obs_data.size(), timed_out);
    end
    foreach (obs_data[k]) begin
      total++; if (obs_data[k] !== exp_byte(2 + k)) begin
        bad++; $display("FAIL basic_data beat=%0d got=%h want=%h", k, obs_data[k], exp_byte(2 + k));
      end
    end
    if (obs_cyc.size() == 3) begin
      total++; if (obs_cyc[0] != int'(W)) begin
        bad++; $display("FAIL basic_latency got=%0d want=%0d", obs_cyc[0], W);
      end
      for (int k = 1; k < 3; k++) begin
        total++; if (obs_cyc[k] - obs_cyc[k-1] != int'(W) + 1) begin
          bad++; $display("FAIL basic_rate beat=%0d got=%0d want=%0d", k,
                          obs_cyc[k] - obs_cyc[k-1], W + 1);
        end
      end
      total++; if (done_cyc != obs_cyc[2] + 1) begin
        bad++; $display("FAIL basic_done_time got=%0d want=%0d", done_cyc, obs_cyc[2] + 1);
      end
    end
    total++; if (done_cnt != 1 || busy_bad != 0) begin
      bad++; $display("FAIL basic_done_busy got=%0d/%0d want=1/0", done_cnt, busy_bad);
    end
  endtask

  task automatic test_wrap();
    collect_burst(4'd14, 5'd4, 0, 0, 0, -1, 0);
    total++; if (obs_data.size() != 4) begin
      bad++; $display("FAIL wrap_count got=%0d want=4", obs_data.size());
    end
    foreach (obs_data[k]) begin
      total++; if (obs_addr[k] !== 4'(14 + k) || obs_data[k] !== exp_byte(14 + k)) begin
        bad++; $display("FAIL wrap_beat beat=%0d got=%h/%h want=%h/%h", k, obs_addr[k],
                        obs_data[k], 4'(14 + k), exp_byte(14 + k));
      end
    end
  endtask

  task automatic test_len_zero();
    int mism = 0;
    collect_burst(4'd0, 5'd0, 0, 0, 0, -1, 0);
    total++; if (obs_data.size() != 16) begin
      bad++; $display("FAIL len0_count got=%0d want=16", obs_data.size());
    end
    foreach (obs_data[k]) if (obs_data[k] !== exp_byte(k)) mism++;
    total++; if (mism != 0) begin bad++; $display("FAIL len0_data got=%0d bad beats want=0", mism); end
    total++; if (busy_bad != 0 || done_cnt != 1) begin
      bad++; $display("FAIL len0_busy got=%0d/%0d want=0/1", busy_bad, done_cnt);
    end
  endtask

  task automatic test_stall();
    collect_burst(4'd0, 5'd6, 2, 1, 5, -1, 0);
    total++; if (obs_data.size() != 6 || stall_bad != 0) begin
      bad++; $display("FAIL stall_hold got=%0d beats %0d errs want=6/0", obs_data.size(), stall_bad);
    end
    foreach (obs_data[k]) begin
      total++; if (obs_data[k] !== exp_byte(k)) begin
        bad++; $display("FAIL stall_data beat=%0d got=%h want=%h", k, obs_data[k], exp_byte(k));
      end
    end
    if (obs_cyc.size() >= 2) begin
      total++; if (obs_cyc[1] - obs_cyc[0] != int'(W) + 6) begin
        bad++; $display("FAIL stall_gap got=%0d want=%0d", obs_cyc[1] - obs_cyc[0], W + 6);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit hs = 0;
    int dn = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 4'd3; burst_len = 5'd8; dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!hs && n < 50) begin
      @(negedge clk);
      if (dout_valid === 1'b1) hs = 1;
      n++;
    end
    total++; if (!hs) begin bad++; $display("FAIL rstmid_first_beat got=none want=beat"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if ({busy, done, rom_cs, rom_read_en, rom_addrb, dout, dout_valid} !== 17'd0) begin
      bad++; $display("FAIL rstmid_outputs got=%h want=0",
                      {busy, done, rom_cs, rom_read_en, rom_addrb, dout, dout_valid});
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dn++;
    end
    total++; if (dn != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", dn); end
    collect_burst(4'd5, 5'd2, 0, 0, 0, -1, 0);
    total++; if (obs_data.size() != 2 || obs_data[0] !== 8'hA5 || obs_data[1] !== 8'hA6) begin
      bad++; $display("FAIL rstmid_restart got=%0d beats want=A5,A6", obs_data.size());
    end
  endtask

  task automatic test_start_ignored();
    int mism = 0;
    collect_burst(4'd9, 5'd5, 0, 0, 0, 3, 1);
    foreach (obs_data[k]) if (obs_data[k] !== exp_byte(9 + k)) mism++;
    total++; if (obs_data.size() != 5 || mism != 0) begin
      bad++; $display("FAIL busy_start got=%0d beats %0d wrong want=5/0", obs_data.size(), mism);
    end
    total++; if (done_cnt != 1 || busy_bad != 0) begin
      bad++; $display("FAIL fin_start got=%0d done %0d busy errs want=1/0", done_cnt, busy_bad);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic [3:0] b;
      logic [4:0] l;
      int mism, n;
      logic [7:0] x;
      b = 4'($urandom); l = 5'($urandom_range(0, 16));
      n = exp_beats(l); mism = 0; x = '0;
      collect_burst(b, l, 1, 0, 0, -1, 0);
      for (int k = 0; k < n; k++) x ^= exp_byte(int'(b) + k);
      foreach (obs_data[k]) if (obs_data[k] !== exp_byte(int'(b) + k)) mism++;
      total++; if (timed_out || obs_data.size() != n || mism != 0 || stall_bad != 0) begin
        bad++; $display("FAIL random it=%0d base=%0d len=%0d got=%0d beats %0d wrong want=%0d/0",
                        it, b, l, obs_data.size(), mism, n);
      end
`ifdef BURST_CHECKSUM_EN
      total++; if (done_chk !== x) begin
        bad++; $display("FAIL random_chk it=%0d got=%h want=%h", it, done_chk, x);
      end
`else
      if (x === 8'hxx) $display("unexpected unknown in model");
`endif
    end
  endtask

`ifdef BURST_CHECKSUM_EN
  task automatic test_checksum();
    collect_burst(4'd0, 5'd2, 0, 0, 0, -1, 0);
    total++; if (done_chk !== 8'h01) begin
      bad++; $display("FAIL chk_done got=%h want=01", done_chk);
    end
    repeat (3) @(negedge clk);
    total++; if (chk !== 8'h01) begin bad++; $display("FAIL chk_hold got=%h want=01", chk); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'hA0 + 8'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_len_zero();
    test_stall();
    test_reset_mid();
    test_start_ignored();
    test_random();
`ifdef BURST_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
